// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
//   Program counter with a circular hardware return stack. Sits between the
//   decoder (op/page/target) and instruction memory (pc). State advances only
//   on clock edges where the one-cycle step strobe is high.
//
//   Ops: 0 HOLD, 1 INC, 2 SKIP (+2), 3 JUMP, 4 CALL, 5 RET, 6 LOAD, 7 INC.
//
//   Optional feature macro: STACK_OVF_TRAP_EN
//     undefined : CALL while full overwrites the oldest entry;
//                 RET while empty pops a stale entry with pointer wrap.
//     defined   : both faults leave the stack untouched and load TRAP_VECTOR.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   step        in   advance strobe
//   op          in   3-bit operation code
//   target      in   JUMP_W-bit low bits of a new PC
//   page        in   upper PC bits for JUMP/CALL/LOAD (1-bit tie-off when
//                    JUMP_W == PC_W; ignored in that case)
//   clear_flags in   synchronous clear of the ovf/unf sticky flags
//   pc          out  registered program counter
//   depth       out  number of valid stack entries
//   stack_full  out  depth == DEPTH (registered)
//   stack_empty out  depth == 0 (registered)
//   ovf         out  sticky: push attempted while full
//   unf         out  sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module pc_stack_unit #(
  parameter int PC_W         = 13,
  parameter int JUMP_W       = 11,
  parameter int DEPTH        = 8,
  parameter int RESET_VECTOR = 0,
  parameter int TRAP_VECTOR  = 4,
  localparam int PG_W        = PC_W - JUMP_W,
  localparam int PG_PW       = (PG_W > 0) ? PG_W : 1,
  localparam int DEPTH_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic [2:0]         op,
  input  logic [JUMP_W-1:0]  target,
  input  logic [PG_PW-1:0]   page,
  input  logic               clear_flags,
  output logic [PC_W-1:0]    pc,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               ovf,
  output logic               unf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_SKIP = 3'd2;
  localparam logic [2:0] OP_JUMP = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_LOAD = 3'd6;
  localparam logic [2:0] OP_INC7 = 3'd7;

  localparam logic [PC_W-1:0]    PC_ONE     = PC_W'(1);
  localparam logic [PC_W-1:0]    PC_TWO     = PC_W'(2);
  localparam logic [PC_W-1:0]    PC_RESET   = PC_W'(RESET_VECTOR);
  localparam logic [PC_W-1:0]    PC_TRAP    = PC_W'(TRAP_VECTOR);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = DEPTH_W'(0);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ZERO   = PTR_W'(0);
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(DEPTH - 1);

  // Registered state
  logic [PC_W-1:0]    pc_r;
  logic [PTR_W-1:0]   top_r;
  logic [DEPTH_W-1:0] depth_r;
  logic               full_r;
  logic               empty_r;
  logic               ovf_r;
  logic               unf_r;

  // Return-stack storage; contents are don't-care after reset
  logic [PC_W-1:0]    stack_mem_r [DEPTH];

  // Next-state and control
  logic [PC_W-1:0]    pc_nxt_s;
  logic [PTR_W-1:0]   top_nxt_s;
  logic [DEPTH_W-1:0] depth_nxt_s;
  logic               ovf_nxt_s;
  logic               unf_nxt_s;
  logic               set_ovf_s;
  logic               set_unf_s;
  logic               push_s;
  logic [PC_W-1:0]    push_data_s;
  logic [PTR_W-1:0]   ptr_inc_s;
  logic [PTR_W-1:0]   ptr_dec_s;
  logic [PC_W-1:0]    jump_pc_s;
  logic               is_full_s;
  logic               is_empty_s;

  // Circular pointer neighbours and the {page,target} jump address
  always_comb begin
    ptr_inc_s  = (top_r == PTR_LAST) ? PTR_ZERO : (top_r + PTR_ONE);
    ptr_dec_s  = (top_r == PTR_ZERO) ? PTR_LAST : (top_r - PTR_ONE);
    // With JUMP_W == PC_W the shift pushes the page tie-off entirely out
    jump_pc_s  = (PC_W'(page) << JUMP_W) | PC_W'(target);
    is_full_s  = (depth_r == DEPTH_MAX);
    is_empty_s = (depth_r == DEPTH_ZERO);
  end

  // Operation decode: next pc, stack pointer/depth, push request, flag sets
  always_comb begin
    pc_nxt_s    = pc_r;
    top_nxt_s   = top_r;
    depth_nxt_s = depth_r;
    push_s      = 1'b0;
    push_data_s = pc_r + PC_ONE;
    set_ovf_s   = 1'b0;
    set_unf_s   = 1'b0;
    if (step) begin
      case (op)
        OP_HOLD: pc_nxt_s = pc_r;
        OP_INC,
        OP_INC7: pc_nxt_s = pc_r + PC_ONE;
        OP_SKIP: pc_nxt_s = pc_r + PC_TWO;
        OP_JUMP,
        OP_LOAD: pc_nxt_s = jump_pc_s;
        OP_CALL: begin
          if (is_full_s) begin
            set_ovf_s = 1'b1;
`ifdef STACK_OVF_TRAP_EN
            pc_nxt_s  = PC_TRAP;
`else
            // Overwrite the oldest entry; depth stays saturated
            push_s    = 1'b1;
            top_nxt_s = ptr_inc_s;
            pc_nxt_s  = jump_pc_s;
`endif
          end else begin
            push_s      = 1'b1;
            top_nxt_s   = ptr_inc_s;
            depth_nxt_s = depth_r + DEPTH_ONE;
            pc_nxt_s    = jump_pc_s;
          end
        end
        OP_RET: begin
          if (is_empty_s) begin
            set_unf_s = 1'b1;
`ifdef STACK_OVF_TRAP_EN
            pc_nxt_s  = PC_TRAP;
`else
            // Stale pop: pointer wraps, depth stays at zero
            top_nxt_s = ptr_dec_s;
            pc_nxt_s  = stack_mem_r[ptr_dec_s];
`endif
          end else begin
            top_nxt_s   = ptr_dec_s;
            depth_nxt_s = depth_r - DEPTH_ONE;
            pc_nxt_s    = stack_mem_r[ptr_dec_s];
          end
        end
        default: pc_nxt_s = pc_r;
      endcase
    end else begin
      pc_nxt_s = pc_r;
    end
    // Sticky flags: a set on this edge wins over clear_flags
    ovf_nxt_s = set_ovf_s | (ovf_r & ~clear_flags);
    unf_nxt_s = set_unf_s | (unf_r & ~clear_flags);
  end

  // Control and status registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r    <= PC_RESET;
      top_r   <= PTR_ZERO;
      depth_r <= DEPTH_ZERO;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      top_r   <= top_nxt_s;
      depth_r <= depth_nxt_s;
      full_r  <= (depth_nxt_s == DEPTH_MAX);
      empty_r <= (depth_nxt_s == DEPTH_ZERO);
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  // Stack RAM write port; no reset on storage
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      stack_mem_r[top_r] <= push_data_s;
    end
  end

  assign pc          = pc_r;
  assign depth       = depth_r;
  assign stack_full  = full_r;
  assign stack_empty = empty_r;
  assign ovf         = ovf_r;
  assign unf         = unf_r;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, SKIP = 3'd2, JUMP = 3'd3,
                         CALL = 3'd4, RET = 3'd5, LOAD = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic [2:0]  op;
  logic [10:0] target;
  logic [1:0]  page;
  logic        clear_flags;
  logic [12:0] pc;
  logic [3:0]  depth;
  logic        stack_full, stack_empty, ovf, unf;

  int n_vec = 0;
  int n_err = 0;

  pc_stack_unit dut (
    .clk(clk), .reset(reset), .step(step), .op(op), .target(target),
    .page(page), .clear_flags(clear_flags), .pc(pc), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One step edge with the given operation; outputs settle 1 time unit later
  task automatic do_op(input logic [2:0] o, input logic [1:0] pg, input logic [10:0] tg);
    op = o; page = pg; target = tg; step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  initial begin
    reset = 1'b1; step = 1'b1; op = INC; page = 2'd0; target = 11'd0; clear_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_empty", 32'(stack_empty), 32'd1);
    check("rst_full", 32'(stack_full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_unf", 32'(unf), 32'd0);

    // Release with INC stepping every cycle
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("inc_run", 32'(pc), 32'(i));
    end
    step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("step_low_hold", 32'(pc), 32'd3);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", 32'(pc), 32'h0);
    check("async_rst_depth", 32'(depth), 32'd0);
    check("async_rst_flags", 32'({ovf, unf}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // SKIP / JUMP / LOAD / wrap
    do_op(LOAD, 2'd0, 11'd5);      check("load5", 32'(pc), 32'd5);
    do_op(SKIP, 2'd0, 11'd0);      check("skip", 32'(pc), 32'd7);
    do_op(JUMP, 2'b01, 11'h123);   check("jump", 32'(pc), 32'h0923);
    do_op(HOLD, 2'd0, 11'd0);      check("hold", 32'(pc), 32'h0923);
    do_op(LOAD, 2'b11, 11'h7FF);   check("load_max", 32'(pc), 32'h1FFF);
    do_op(INC, 2'd0, 11'd0);       check("inc_wrap", 32'(pc), 32'h0000);
    do_op(LOAD, 2'd0, 11'h7FF);
    do_op(SKIP, 2'd0, 11'd0);      check("skip_page", 32'(pc), 32'h0801);

    // Nested CALL/RET
    do_op(LOAD, 2'd0, 11'd10);
    do_op(CALL, 2'd0, 11'd100);    check("call1_pc", 32'(pc), 32'd100);
    do_op(CALL, 2'd0, 11'd200);    check("call2_pc", 32'(pc), 32'd200);
    check("call2_depth", 32'(depth), 32'd2);
    do_op(RET, 2'd0, 11'd0);       check("ret1_pc", 32'(pc), 32'd101);
    check("ret1_depth", 32'(depth), 32'd1);
    do_op(RET, 2'd0, 11'd0);       check("ret2_pc", 32'(pc), 32'd11);
    check("ret2_depth", 32'(depth), 32'd0);
    check("ret2_empty", 32'(stack_empty), 32'd1);
    check("ret2_unf", 32'(unf), 32'd0);

`ifdef STACK_OVF_TRAP_EN
    // Trap on underflow
    do_op(RET, 2'd0, 11'd0);
    check("trap_unf_pc", 32'(pc), 32'd4);
    check("trap_unf_flag", 32'(unf), 32'd1);
    check("trap_unf_depth", 32'(depth), 32'd0);
    // Fill to 8 entries (pushes 1..8), then overflow traps
    do_op(LOAD, 2'd0, 11'd0);
    for (int i = 1; i <= 8; i++) do_op(CALL, 2'd0, 11'(i));
    check("trap_fill_full", 32'(stack_full), 32'd1);
    do_op(CALL, 2'd0, 11'd50);
    check("trap_ovf_pc", 32'(pc), 32'd4);
    check("trap_ovf_depth", 32'(depth), 32'd8);
    check("trap_ovf_flag", 32'(ovf), 32'd1);
    do_op(RET, 2'd0, 11'd0);
    check("trap_top_intact", 32'(pc), 32'd8);
    check("trap_ret_depth", 32'(depth), 32'd7);
`else
    // Overflow: 9 CALLs from pc 0..8 push 1..9; the 9th overwrites entry 1
    do_op(LOAD, 2'd0, 11'd0);
    for (int i = 1; i <= 9; i++) begin
      do_op(CALL, 2'd0, 11'(i));
      if (i == 8) begin
        check("fill8_ovf", 32'(ovf), 32'd0);
        check("fill8_full", 32'(stack_full), 32'd1);
      end
    end
    check("ovf_pc", 32'(pc), 32'd9);
    check("ovf_depth", 32'(depth), 32'd8);
    check("ovf_full", 32'(stack_full), 32'd1);
    check("ovf_flag", 32'(ovf), 32'd1);
    for (int k = 0; k < 8; k++) begin
      do_op(RET, 2'd0, 11'd0);
      check("ovf_ret_pc", 32'(pc), 32'(9 - k));
      check("ovf_ret_depth", 32'(depth), 32'(7 - k));
    end
    check("drain_empty", 32'(stack_empty), 32'd1);
    check("drain_unf", 32'(unf), 32'd0);
    // Underflow pops the stale slot 0, which holds 9
    do_op(RET, 2'd0, 11'd0);
    check("unf_pc", 32'(pc), 32'd9);
    check("unf_flag", 32'(unf), 32'd1);
    check("unf_depth", 32'(depth), 32'd0);
    // clear_flags honoured with step low; CALL with step low does nothing
    op = CALL; target = 11'd77; clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    check("clear_ovf", 32'(ovf), 32'd0);
    check("clear_unf", 32'(unf), 32'd0);
    check("nostep_pc", 32'(pc), 32'd9);
    check("nostep_depth", 32'(depth), 32'd0);
    // Set on the same edge as clear: set wins
    do_op(LOAD, 2'd0, 11'd0);
    for (int i = 1; i <= 8; i++) do_op(CALL, 2'd0, 11'(i));
    check("refill_ovf", 32'(ovf), 32'd0);
    clear_flags = 1'b1;
    do_op(CALL, 2'd0, 11'd20);
    clear_flags = 1'b0;
    check("set_wins_ovf", 32'(ovf), 32'd1);
    check("set_wins_pc", 32'(pc), 32'd20);
    check("set_wins_depth", 32'(depth), 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
